// File: rtl/alarm_timekeeper_pkg.sv
// Shared field widths, range limits and ringer states for the alarm timekeeper.
// Pure definitions; no logic state lives here.
package alarm_pkg;

    localparam int TW = 7;

    localparam logic [TW-1:0] SECS_MAX = 7'd59;
    localparam logic [TW-1:0] MINS_MAX = 7'd59;
    localparam logic [TW-1:0] HRS_MAX  = 7'd23;
    localparam logic [TW-1:0] T_ONE    = 7'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        HOLD   = 2'd2,
        SNOOZE = 2'd3
    } ring_state_t;

    // Modulo increment that also recovers any out-of-range value to zero.
    function automatic logic [TW-1:0] wrap_inc(input logic [TW-1:0] v, input logic [TW-1:0] vmax);
        return (v >= vmax) ? '0 : v + T_ONE;
    endfunction

endpackage

// File: rtl/alarm_timekeeper_if.sv
// Control, time and alarm bundle between the timekeeper and its surroundings.
// master = timekeeper (drives time/alarm/ring), slave = user panel plus comparator.
interface alarm_timekeeper_if;
    import alarm_pkg::*;

    logic          sec_tick;
    logic          timeset;
    logic          alarmset;
    logic          minadv;
    logic          hrsadv;
    logic          alarm_en;
    logic          stop;
    logic          snooze;
    logic          buzz_in;
    logic [TW-1:0] tsec;
    logic [TW-1:0] tmin;
    logic [TW-1:0] thrs;
    logic [TW-1:0] amin;
    logic [TW-1:0] ahrs;
    logic          ring_out;

    modport master (
        input  sec_tick, timeset, alarmset, minadv, hrsadv, alarm_en, stop, snooze, buzz_in,
        output tsec, tmin, thrs, amin, ahrs, ring_out
    );

    modport slave (
        output sec_tick, timeset, alarmset, minadv, hrsadv, alarm_en, stop, snooze, buzz_in,
        input  tsec, tmin, thrs, amin, ahrs, ring_out
    );

endinterface

// File: rtl/alarm_timekeeper_rise_detect.sv
// Registered 0->1 detector: one pulse per press however long the button is held.
// Latency: pulse is valid the clk after the rising input is sampled; no backpressure.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/alarm_timekeeper.sv
// Time-of-day counter, alarm registers and ring controller; ALARM_SNOOZE_EN adds snooze.
// Latency: buttons act 2 clks after press, ring_out 1 clk after qualifying buzz_in; no backpressure.
module alarm_timekeeper
    import alarm_pkg::*;
#(
    parameter int RING_SECS     = 60,
    parameter int SNOOZE_MINS   = 9,
    parameter int ALARM_RST_HRS = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    alarm_timekeeper_if.master bus
);

    localparam logic [TW-1:0] RING_LOAD = TW'(RING_SECS);
    localparam logic [TW-1:0] AHRS_RST  = TW'(ALARM_RST_HRS);
    localparam int            SNZ_TICKS = SNOOZE_MINS * 60;
    localparam int            SW        = $clog2(SNZ_TICKS + 1);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNZ_TICKS);

    logic [TW-1:0] tsec, tmin, thrs, amin, ahrs;
    logic [TW-1:0] ring_cnt, ring_nxt;
    ring_state_t   state, state_nxt;
    logic          min_rise, hrs_rise, stop_rise;

    rise_detect u_min  (.clk(clk), .reset_n(reset_n), .d(bus.minadv), .rise(min_rise));
    rise_detect u_hrs  (.clk(clk), .reset_n(reset_n), .d(bus.hrsadv), .rise(hrs_rise));
    rise_detect u_stop (.clk(clk), .reset_n(reset_n), .d(bus.stop),   .rise(stop_rise));

`ifdef ALARM_SNOOZE_EN
    logic          snz_rise;
    logic [SW-1:0] snz_cnt, snz_nxt;

    rise_detect u_snz (.clk(clk), .reset_n(reset_n), .d(bus.snooze), .rise(snz_rise));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) snz_cnt <= '0;
        else          snz_cnt <= snz_nxt;
    end
`else
    logic unused_snooze;
    assign unused_snooze = bus.snooze ^ (^SNZ_LOAD);
`endif

    // Time setting freezes the seconds at zero so a released clock starts on a minute boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tsec <= '0;
            tmin <= '0;
            thrs <= '0;
            amin <= '0;
            ahrs <= AHRS_RST;
        end else if (bus.timeset) begin
            tsec <= '0;
            if (min_rise) tmin <= wrap_inc(tmin, MINS_MAX);
            if (hrs_rise) thrs <= wrap_inc(thrs, HRS_MAX);
        end else begin
            if (bus.sec_tick) begin
                tsec <= wrap_inc(tsec, SECS_MAX);
                if (tsec >= SECS_MAX) begin
                    tmin <= wrap_inc(tmin, MINS_MAX);
                    if (tmin >= MINS_MAX) thrs <= wrap_inc(thrs, HRS_MAX);
                end
            end
            if (bus.alarmset) begin
                if (min_rise) amin <= wrap_inc(amin, MINS_MAX);
                if (hrs_rise) ahrs <= wrap_inc(ahrs, HRS_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ring_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ring_cnt <= ring_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ring_nxt  = ring_cnt;
`ifdef ALARM_SNOOZE_EN
        snz_nxt   = snz_cnt;
`endif
        case (state)
            IDLE: begin
                if (bus.alarm_en && bus.buzz_in && !bus.timeset && !bus.alarmset) begin
                    state_nxt = RING;
                    ring_nxt  = RING_LOAD;
                end
            end
            RING: begin
                if (stop_rise || !bus.alarm_en || bus.timeset || bus.alarmset) begin
                    state_nxt = HOLD;
`ifdef ALARM_SNOOZE_EN
                end else if (snz_rise) begin
                    state_nxt = SNOOZE;
                    snz_nxt   = SNZ_LOAD;
`endif
                end else if (bus.sec_tick) begin
                    if (ring_cnt <= T_ONE) begin
                        state_nxt = HOLD;
                        ring_nxt  = '0;
                    end else begin
                        ring_nxt  = ring_cnt - T_ONE;
                    end
                end
            end
            // Wait out the matching minute so one alarm gives one ring.
            HOLD: begin
                if (!bus.buzz_in) state_nxt = IDLE;
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (stop_rise || !bus.alarm_en) begin
                    state_nxt = HOLD;
                end else if (bus.sec_tick) begin
                    if (snz_cnt <= SW'(1)) begin
                        state_nxt = RING;
                        ring_nxt  = RING_LOAD;
                        snz_nxt   = '0;
                    end else begin
                        snz_nxt   = snz_cnt - SW'(1);
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.tsec     = tsec;
    assign bus.tmin     = tmin;
    assign bus.thrs     = thrs;
    assign bus.amin     = amin;
    assign bus.ahrs     = ahrs;
    assign bus.ring_out = (state == RING);

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Scenario bench for alarm_timekeeper with a seconds-of-day reference model.
// The comparator driving buzz_in is modelled here from the DUT's time/alarm outputs.
module tb_alarm_timekeeper;

    localparam int RING_SECS     = 60;
    localparam int SNOOZE_MINS   = 9;
    localparam int ALARM_RST_HRS = 7;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    alarm_timekeeper_if bus();

    alarm_timekeeper #(
        .RING_SECS    (RING_SECS),
        .SNOOZE_MINS  (SNOOZE_MINS),
        .ALARM_RST_HRS(ALARM_RST_HRS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus.buzz_in = (bus.tmin == bus.amin) && (bus.thrs == bus.ahrs);

    // Reference: time of day as a plain seconds count, alarm as hour/minute, ringer as flags.
    int         m_secs = 0, m_amin = 0, m_ahrs = ALARM_RST_HRS, m_left = 0, m_snz_left = 0;
    bit         m_ring = 0, m_hold = 0, m_snz = 0;
    logic [3:0] h1 = '0, h2 = '0;

    always @(posedge clk or negedge reset_n) begin : model
        logic [3:0] btn, pr;
        bit         buzz, ts, as, tk, en;
        int         h, m;
        if (!reset_n) begin
            m_secs = 0; m_amin = 0; m_ahrs = ALARM_RST_HRS; m_left = 0; m_snz_left = 0;
            m_ring = 0; m_hold = 0; m_snz = 0; h1 = '0; h2 = '0;
        end else begin
            btn  = {bus.snooze, bus.stop, bus.hrsadv, bus.minadv};
            pr   = h1 & ~h2;
            h2   = h1;
            h1   = btn;
            ts   = bus.timeset; as = bus.alarmset; tk = bus.sec_tick; en = bus.alarm_en;
            buzz = (m_secs / 60) == (m_ahrs * 60 + m_amin);
            if (m_ring) begin
                if (pr[2] || !en || ts || as) begin m_ring = 0; m_hold = 1; end
`ifdef ALARM_SNOOZE_EN
                else if (pr[3]) begin m_ring = 0; m_snz = 1; m_snz_left = SNOOZE_MINS * 60; end
`endif
                else if (tk) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_ring = 0; m_hold = 1; end
                end
            end
`ifdef ALARM_SNOOZE_EN
            else if (m_snz) begin
                if (pr[2] || !en) begin m_snz = 0; m_hold = 1; end
                else if (tk) begin
                    m_snz_left = m_snz_left - 1;
                    if (m_snz_left == 0) begin m_snz = 0; m_ring = 1; m_left = RING_SECS; end
                end
            end
`endif
            else if (m_hold) begin
                if (!buzz) m_hold = 0;
            end else if (en && buzz && !ts && !as) begin
                m_ring = 1; m_left = RING_SECS;
            end
            h = m_secs / 3600;
            m = (m_secs / 60) % 60;
            if (ts) begin
                if (pr[0]) m = (m + 1) % 60;
                if (pr[1]) h = (h + 1) % 24;
                m_secs = h * 3600 + m * 60;
            end else begin
                if (tk) m_secs = (m_secs + 1) % 86400;
                if (as) begin
                    if (pr[0]) m_amin = (m_amin + 1) % 60;
                    if (pr[1]) m_ahrs = (m_ahrs + 1) % 24;
                end
            end
        end
    end

    function automatic logic [35:0] model_vec();
        return {7'(m_secs % 60), 7'((m_secs / 60) % 60), 7'(m_secs / 3600), 7'(m_amin), 7'(m_ahrs), m_ring};
    endfunction

    function automatic logic [35:0] dut_vec();
        return {bus.tsec, bus.tmin, bus.thrs, bus.amin, bus.ahrs, bus.ring_out};
    endfunction

    // One clock: inputs change just after a falling edge, outputs are read at the next one.
    task automatic cyc(input bit t);
        bus.sec_tick = t;
        @(negedge clk);
        bus.sec_tick = 1'b0;
    endtask

    task automatic press(input int which);
        case (which)
            0:       bus.minadv = 1'b1;
            1:       bus.hrsadv = 1'b1;
            2:       bus.stop   = 1'b1;
            default: bus.snooze = 1'b1;
        endcase
        cyc(0);
        bus.minadv = 1'b0; bus.hrsadv = 1'b0; bus.stop = 1'b0; bus.snooze = 1'b0;
        cyc(0);
    endtask

    task automatic set_time(input int h, input int m);
        int nh, nm;
        bus.timeset = 1'b1;
        cyc(0);
        nh = (h - m_secs / 3600 + 24) % 24;
        nm = (m - (m_secs / 60) % 60 + 60) % 60;
        repeat (nh) press(1);
        repeat (nm) press(0);
        bus.timeset = 1'b0;
        cyc(0);
    endtask

    task automatic set_alarm(input int h, input int m);
        int nh, nm;
        bus.alarmset = 1'b1;
        cyc(0);
        nh = (h - m_ahrs + 24) % 24;
        nm = (m - m_amin + 60) % 60;
        repeat (nh) press(1);
        repeat (nm) press(0);
        bus.alarmset = 1'b0;
        cyc(0);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [35:0] rst_exp;
        rst_exp = {7'd0, 7'd0, 7'd0, 7'd0, 7'(ALARM_RST_HRS), 1'b0};
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== rst_exp) begin
            errors++; $display("FAIL reset_initial dut=%h expected=%h", dut_vec(), rst_exp);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) cyc(1);
        checks++;
        if (bus.tsec !== 7'd30 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL count_30 dut=%h expected=%h", dut_vec(), model_vec());
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== rst_exp) begin
            errors++; $display("FAIL reset_midcount dut=%h expected=%h", dut_vec(), rst_exp);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_held_button();
        int exp_v;
        bus.timeset = 1'b1;
        cyc(0);
        exp_v = ((m_secs / 60) % 60 + 1) % 60;
        bus.minadv = 1'b1;
        repeat (20) cyc(0);
        bus.minadv = 1'b0;
        cyc(0); cyc(0);
        checks++;
        if (bus.tmin !== 7'(exp_v)) begin
            errors++; $display("FAIL held_tmin got=%0d expected=%0d", bus.tmin, exp_v);
        end
        bus.timeset  = 1'b0;
        bus.alarmset = 1'b1;
        cyc(0);
        exp_v = (m_amin + 1) % 60;
        bus.minadv = 1'b1;
        repeat (20) cyc(0);
        bus.minadv = 1'b0;
        cyc(0); cyc(0);
        checks++;
        if (bus.amin !== 7'(exp_v)) begin
            errors++; $display("FAIL held_amin got=%0d expected=%0d", bus.amin, exp_v);
        end
        bus.alarmset = 1'b0;
        cyc(0);
    endtask

    task automatic test_rollover();
        set_time(23, 59);
        checks++;
        if (bus.thrs !== 7'd23 || bus.tmin !== 7'd59 || bus.tsec !== 7'd0) begin
            errors++; $display("FAIL set_2359 got=%0d:%0d:%0d expected=23:59:0", bus.thrs, bus.tmin, bus.tsec);
        end
        repeat (60) cyc(1);
        checks++;
        if (bus.thrs !== 7'd0 || bus.tmin !== 7'd0 || bus.tsec !== 7'd0) begin
            errors++; $display("FAIL rollover got=%0d:%0d:%0d expected=0:0:0", bus.thrs, bus.tmin, bus.tsec);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL rollover_model dut=%h expected=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_ring_timeout();
        int bad;
        do_reset();
        set_alarm(0, 1);
        bus.alarm_en = 1'b1;
        repeat (59) cyc(1);
        checks++;
        if (bus.tsec !== 7'd59 || bus.ring_out !== 1'b0) begin
            errors++; $display("FAIL pre_ring tsec=%0d ring=%b expected 59 0", bus.tsec, bus.ring_out);
        end
        cyc(1);
        checks++;
        if (bus.buzz_in !== 1'b1 || bus.ring_out !== 1'b0) begin
            errors++; $display("FAIL buzz_edge buzz=%b ring=%b expected 1 0", bus.buzz_in, bus.ring_out);
        end
        cyc(0);
        checks++;
        if (bus.ring_out !== 1'b1) begin
            errors++; $display("FAIL ring_rise got=%b expected=1", bus.ring_out);
        end
        repeat (RING_SECS - 1) cyc(1);
        checks++;
        if (bus.ring_out !== 1'b1) begin
            errors++; $display("FAIL ring_last_sec got=%b expected=1", bus.ring_out);
        end
        cyc(1);
        checks++;
        if (bus.ring_out !== 1'b0) begin
            errors++; $display("FAIL ring_timeout got=%b expected=0", bus.ring_out);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(i[0]);
            if (bus.ring_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL no_retrigger ring_high_cycles=%0d expected=0", bad);
        end
    endtask

    task automatic test_stop();
        int bad;
        set_time(0, 0);
        repeat (60) cyc(1);
        cyc(0);
        checks++;
        if (bus.ring_out !== 1'b1) begin
            errors++; $display("FAIL stop_setup_ring got=%b expected=1", bus.ring_out);
        end
        repeat (5) cyc(1);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        cyc(0);
        checks++;
        if (bus.ring_out !== 1'b0) begin
            errors++; $display("FAIL stop_with_tick got=%b expected=0", bus.ring_out);
        end
        bad = 0;
        for (int i = 0; i < 54; i++) begin
            cyc(1);
            if (bus.ring_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || bus.tmin !== 7'd2) begin
            errors++; $display("FAIL stop_rest_of_minute high=%0d tmin=%0d expected 0 2", bad, bus.tmin);
        end
        set_time(23, 59);
        repeat (60) cyc(1);
        checks++;
        if (dut_vec() !== {7'd0, 7'd0, 7'd0, 7'd1, 7'd0, 1'b0}) begin
            errors++; $display("FAIL next_day_midnight dut=%h expected=%h", dut_vec(), {7'd0, 7'd0, 7'd0, 7'd1, 7'd0, 1'b0});
        end
        repeat (60) cyc(1);
        cyc(0);
        checks++;
        if (bus.ring_out !== 1'b1) begin
            errors++; $display("FAIL next_day_ring got=%b expected=1", bus.ring_out);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.ring_out !== 1'b0 || bus.ahrs !== 7'(ALARM_RST_HRS) || bus.amin !== 7'd0) begin
            errors++; $display("FAIL reset_midring ring=%b ahrs=%0d amin=%0d expected 0 %0d 0", bus.ring_out, bus.ahrs, bus.amin, ALARM_RST_HRS);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int mod;
        mod = (m_secs / 60 + 1) % 1440;
        set_alarm(mod / 60, mod % 60);
        bus.alarm_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) bus.timeset  = !bus.timeset;
            if ($urandom_range(0, 39) == 0) bus.alarmset = !bus.alarmset;
            if ($urandom_range(0, 59) == 0) bus.alarm_en = !bus.alarm_en;
            bus.minadv = ($urandom_range(0, 5) == 0);
            bus.hrsadv = ($urandom_range(0, 7) == 0);
            bus.stop   = ($urandom_range(0, 49) == 0);
            bus.snooze = ($urandom_range(0, 49) == 0);
            cyc($urandom_range(0, 3) != 0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random cyc=%0d dut=%h model=%h", i, dut_vec(), model_vec());
            end
        end
        bus.timeset = 1'b0; bus.alarmset = 1'b0; bus.minadv = 1'b0; bus.hrsadv = 1'b0;
        bus.stop = 1'b0; bus.snooze = 1'b0; bus.alarm_en = 1'b1;
        cyc(0);
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze();
        int bad;
        do_reset();
        set_alarm(0, 1);
        bus.alarm_en = 1'b1;
        repeat (60) cyc(1);
        cyc(0);
        repeat (3) cyc(1);
        press(3);
        checks++;
        if (bus.ring_out !== 1'b0) begin
            errors++; $display("FAIL snooze_silence got=%b expected=0", bus.ring_out);
        end
        bad = 0;
        for (int i = 0; i < SNOOZE_MINS * 60 - 1; i++) begin
            cyc(1);
            if (bus.ring_out !== 1'b0) bad++;
        end
        cyc(1);
        checks++;
        if (bad != 0 || bus.ring_out !== 1'b1) begin
            errors++; $display("FAIL snooze_rering early=%0d ring=%b expected 0 1", bad, bus.ring_out);
        end
        press(3);
        press(2);
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            cyc(1);
            if (bus.ring_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL snooze_stop high=%0d dut=%h model=%h", bad, dut_vec(), model_vec());
        end
    endtask
`endif

    initial begin
        bus.sec_tick = 1'b0; bus.timeset = 1'b0; bus.alarmset = 1'b0; bus.minadv = 1'b0;
        bus.hrsadv = 1'b0; bus.alarm_en = 1'b0; bus.stop = 1'b0; bus.snooze = 1'b0;
        test_reset();
        test_held_button();
        test_rollover();
        test_ring_timeout();
        test_stop();
        test_random();
`ifdef ALARM_SNOOZE_EN
        test_snooze();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
